// File: rtl/pattern_detector_gen.sv
// pattern_detector_gen: serial pattern detector with a run-time loadable
// pattern of 1..PAT_W bits. One data bit is sampled per trig strobe. Outputs
// are a thermometer progress display, a match pulse, a saturating match
// counter, a sticky config error flag and an alive LED.
// Optional feature macro: PATDET_MATCH_CNT_EN builds the match counter.
// When it is undefined, match_cnt is tied to 0 and cnt_clr is ignored.
module pattern_detector_gen #(
   parameter int               PAT_W    = 5,
   parameter int               LEN_W    = 3,
   parameter int               CNT_W    = 8,
   parameter logic [PAT_W-1:0] PAT_INIT = 5'b11010,
   parameter int               LEN_INIT = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             data,
   input  logic             trig,
   input  logic             overlap,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cnt_clr,
   output logic [PAT_W-1:0] progress,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cfg_err,
   output logic             on_led
);

   logic [PAT_W-1:0] pat;
   logic [LEN_W-1:0] len;
   logic [PAT_W-1:0] hist;      // hist[0] is the newest bit
   logic [LEN_W-1:0] vcnt;      // number of valid history bits, 0..PAT_W

   logic [PAT_W-1:0] hist_new;
   logic [LEN_W-1:0] vcnt_new;
   logic [PAT_W-1:0] pat_top;   // active pattern left-aligned to the MSB
   logic [PAT_W-1:0] cand;      // cand[g-1]: a prefix of length g matches
   logic [LEN_W-1:0] k;         // longest prefix matched
   logic [PAT_W-1:0] therm;
   logic             hit;
   logic             len_ok;
   logic             unused_hist_msb;

   // The MSB of hist is shifted out on the next strobe and is never compared.
   assign unused_hist_msb = hist[PAT_W-1];

   assign hist_new = {hist[PAT_W-2:0], data};
   assign vcnt_new = (vcnt == LEN_W'(PAT_W)) ? vcnt : vcnt + 1'b1;
   // Left-align the pattern so that pat[len-1 -: g] becomes pat_top[PAT_W-1 -: g].
   assign pat_top  = pat << (LEN_W'(PAT_W) - len);
   assign len_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));

   // One comparator per candidate prefix length g. A prefix can match only
   // when it fits within both the pattern and the valid history.
   for (genvar g = 1; g <= PAT_W; g++) begin : g_pfx
      assign cand[g-1] = (LEN_W'(g) <= len) && (LEN_W'(g) <= vcnt_new) &&
                         (hist_new[g-1:0] == pat_top[PAT_W-1 -: g]);
   end

   // Select the longest matching prefix (the highest set candidate).
   always_comb begin
      k = '0;
      for (int i = 0; i < PAT_W; i++)
         if (cand[i]) k = LEN_W'(i + 1);
   end

   // Build a thermometer code with the k LSBs set.
   always_comb begin
      therm = '0;
      for (int i = 0; i < PAT_W; i++)
         therm[i] = (LEN_W'(i) < k);
   end

   assign hit = (k == len);

   // Configuration, history, progress and match state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pat      <= PAT_INIT;
         len      <= LEN_W'(LEN_INIT);
         hist     <= '0;
         vcnt     <= '0;
         progress <= '0;
         match    <= 1'b0;
         cfg_err  <= 1'b0;
         on_led   <= 1'b0;
      end else begin
         on_led <= 1'b1;
         match  <= 1'b0;
         if (cfg_load) begin
            // A load always restarts detection. An illegal length keeps
            // the old pattern and flags the error.
            if (len_ok) begin
               pat     <= cfg_pattern;
               len     <= cfg_len;
               cfg_err <= 1'b0;
            end else begin
               cfg_err <= 1'b1;
            end
            vcnt     <= '0;
            progress <= '0;
         end else if (trig) begin
            hist     <= hist_new;
            vcnt     <= (hit && !overlap) ? '0 : vcnt_new;
            progress <= therm;
            match    <= hit;
         end
      end
   end

`ifdef PATDET_MATCH_CNT_EN
   logic match_hit;
   assign match_hit = trig && !cfg_load && hit;

   // Saturating match counter; a clear takes priority over a coincident match.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         match_cnt <= '0;
      else if (cnt_clr)
         match_cnt <= '0;
      else if (match_hit && (match_cnt != {CNT_W{1'b1}}))
         match_cnt <= match_cnt + 1'b1;
   end
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_pattern_detector_gen.sv
// tb_pattern_detector_gen: randomized and directed bench for pattern_detector_gen.
// A queue-based reference model holds the valid bits since the last restart.
// For each strobe it searches for the longest pattern prefix that equals the
// tail of the stream.
module tb_pattern_detector_gen;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       data, trig, overlap, cfg_load, cnt_clr;
   logic [4:0] cfg_pattern;
   logic [2:0] cfg_len;
   logic [4:0] progress;
   logic       match;
   logic [1:0] match_cnt;
   logic       cfg_err;
   logic       on_led;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   bit         q[$];
   logic [4:0] mpat;
   int         mlen;
   logic [4:0] mprog;
   bit         mmatch, merr, mled;
   int         mcnt;

   pattern_detector_gen #(.PAT_W(5), .LEN_W(3), .CNT_W(2)) dut (
      .clk(clk), .reset_n(reset_n), .data(data), .trig(trig), .overlap(overlap),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cnt_clr(cnt_clr), .progress(progress), .match(match),
      .match_cnt(match_cnt), .cfg_err(cfg_err), .on_led(on_led)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      mpat = 5'b11010; mlen = 5; mprog = '0;
      mmatch = 0; merr = 0; mcnt = 0; mled = 0;
   endtask

   // Reference behaviour for one clock edge, based on the inputs being applied.
   task automatic model_step(input logic d, t, ov, ld, input logic [4:0] cp,
                             input logic [2:0] cl, input logic clr);
      int k;
      bit ok;
      mled   = 1;
      mmatch = 0;
      if (ld) begin
         if (cl >= 1 && cl <= 5) begin
            mpat = cp; mlen = int'(cl); merr = 0;
         end else merr = 1;
         q.delete();
         mprog = '0;
      end else if (t) begin
         q.push_back(d);
         if (q.size() > 5) void'(q.pop_front());
         k = 0;
         for (int kk = 1; kk <= mlen; kk++) begin
            if (kk <= q.size()) begin
               ok = 1;
               for (int j = 0; j < kk; j++)
                  if (q[q.size() - kk + j] != mpat[mlen - 1 - j]) ok = 0;
               if (ok) k = kk;
            end
         end
         mprog  = 5'((32'd1 << k) - 1);
         mmatch = (k == mlen);
         if (mmatch && !ov) q.delete();
      end
`ifdef PATDET_MATCH_CNT_EN
      if (clr) mcnt = 0;
      else if (mmatch && mcnt < 3) mcnt++;
`else
      mcnt = 0;
`endif
   endtask

   task automatic cyc(input logic d, t, ov, ld, input logic [4:0] cp,
                      input logic [2:0] cl, input logic clr);
      data = d; trig = t; overlap = ov; cfg_load = ld;
      cfg_pattern = cp; cfg_len = cl; cnt_clr = clr;
      @(posedge clk);
      model_step(d, t, ov, ld, cp, cl, clr);
      #1;
      chk("progress", 32'(progress), 32'(mprog));
      chk("match", 32'(match), 32'(mmatch));
      chk("match_cnt", 32'(match_cnt), 32'(mcnt));
      chk("cfg_err", 32'(cfg_err), 32'(merr));
      chk("on_led", 32'(on_led), 32'(mled));
   endtask

   task automatic strobe(input logic d, input logic ov);
      cyc(d, 1'b1, ov, 1'b0, 5'd0, 3'd0, 1'b0);
   endtask

   task automatic idle(input logic d);
      cyc(d, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
   endtask

   task automatic load(input logic [4:0] cp, input logic [2:0] cl);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, cp, cl, 1'b0);
   endtask

   task automatic clr_cnt();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b1);
   endtask

   logic [4:0] s1_bits;
   logic [5:0] fb_bits;
   logic [4:0] s1_prog [5];
   logic [4:0] fb_prog [6];

   initial begin
      s1_bits = 5'b11010;
      fb_bits = 6'b111010;
      s1_prog = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111};
      fb_prog = '{5'b00001, 5'b00011, 5'b00011, 5'b00111, 5'b01111, 5'b11111};
      reset_n = 1'b0; data = 0; trig = 0; overlap = 0; cfg_load = 0;
      cfg_pattern = '0; cfg_len = '0; cnt_clr = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_progress", 32'(progress), 32'd0);
      chk("rst_match", 32'(match), 32'd0);
      chk("rst_cnt", 32'(match_cnt), 32'd0);
      chk("rst_err", 32'(cfg_err), 32'd0);
      chk("rst_led", 32'(on_led), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Reset-default pattern 11010, non-overlap
      for (int i = 0; i < 5; i++) begin
         strobe(s1_bits[4-i], 1'b0);
         chk("s1_prog_tab", 32'(progress), 32'(s1_prog[i]));
         chk("s1_match_tab", 32'(match), 32'(i == 4));
      end

      // Prefix fallback on the 111010 stream
      load(5'b11010, 3'd5);
      for (int i = 0; i < 6; i++) begin
         strobe(fb_bits[5-i], 1'b0);
         chk("fb_prog_tab", 32'(progress), 32'(fb_prog[i]));
      end

      // Overlap versus non-overlap with pattern 11
      load(5'b00011, 3'd2);
      for (int i = 0; i < 4; i++) begin
         strobe(1'b1, 1'b1);
         chk("ov1_match", 32'(match), 32'(i >= 1));
      end
      load(5'b00011, 3'd2);
      for (int i = 0; i < 4; i++) begin
         strobe(1'b1, 1'b0);
         chk("ov0_match", 32'(match), 32'(i == 1 || i == 3));
      end

      // Sparse strobes with data toggling between them
      load(5'b11010, 3'd5);
      for (int i = 0; i < 5; i++) begin
         strobe(s1_bits[4-i], 1'b0);
         chk("sp_prog_tab", 32'(progress), 32'(s1_prog[i]));
         repeat (i % 4) idle(logic'($urandom_range(0, 1)));
      end

      // Config errors and load-versus-trig priority
      load(5'b10101, 3'd0);
      chk("err_set", 32'(cfg_err), 32'd1);
      for (int i = 0; i < 5; i++) strobe(s1_bits[4-i], 1'b0);
      chk("err_pat_kept", 32'(match), 32'd1);
      load(5'b10101, 3'd6);
      load(5'b11010, 3'd5);
      chk("err_clr", 32'(cfg_err), 32'd0);
      strobe(1'b1, 1'b0);
      strobe(1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 5'b11010, 3'd5, 1'b0);
      chk("ld_trig_prog", 32'(progress), 32'd0);

      // Counter saturation, then a clear in the same cycle as a match
      clr_cnt();
      for (int m = 0; m < 5; m++)
         for (int i = 0; i < 5; i++) strobe(s1_bits[4-i], 1'b0);
      for (int i = 0; i < 4; i++) strobe(s1_bits[4-i], 1'b0);
      cyc(s1_bits[0], 1'b1, 1'b0, 1'b0, 5'd0, 3'd0, 1'b1);
      chk("clr_vs_match", 32'(match_cnt), 32'd0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 4)
            cyc(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), 1'b0, 1'b1,
                5'($urandom), 3'($urandom_range(0, 7)), 1'b0);
         else
            cyc(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0),
                logic'($urandom_range(0, 1)), 1'b0, 5'd0, 3'd0, logic'(r == 99));
      end

      // Asynchronous reset in the middle of a pattern
      load(5'b11010, 3'd5);
      strobe(1'b1, 1'b0);
      strobe(1'b1, 1'b0);
      chk("pre_arst_prog", 32'(progress), 32'd3);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      chk("arst_progress", 32'(progress), 32'd0);
      chk("arst_match", 32'(match), 32'd0);
      chk("arst_cnt", 32'(match_cnt), 32'd0);
      chk("arst_err", 32'(cfg_err), 32'd0);
      chk("arst_led", 32'(on_led), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) strobe(s1_bits[4-i], 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pattern_detector_gen.md
# pattern_detector_gen

Parametrised serial pattern detector. It samples one `data` bit per `trig` strobe and compares the sampled stream against a run-time-loadable pattern of 1 to `PAT_W` bits. Overlapping or non-overlapping matching is selected by input. It drives a thermometer progress display, a one-cycle match pulse, a saturating match counter and an alive indicator. It is the generalised successor of the fixed 5-bit LED pattern FSM, for board-level LED/debug use.

## Interface
- `PAT_W`, 5: maximum pattern length in bits (≥2).
- `LEN_W`, 3: width of length fields; must satisfy 2^LEN_W > PAT_W.
- `CNT_W`, 8: match counter width.
- `PAT_INIT`, 5'b11010: pattern after reset.
- `LEN_INIT`, 5: pattern length after reset.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `data` in 1: serial bit, sampled only when `trig`=1.
- `trig` in 1: sample strobe, one bit per high cycle.
- `overlap` in 1: 1 = overlapping matches, 0 = history cleared after each match; sampled on each `trig`.
- `cfg_load` in 1: load `cfg_pattern`/`cfg_len` and restart detection.
- `cfg_pattern` in PAT_W: new pattern; bit `cfg_len-1` is the first bit expected, bit 0 is the last.
- `cfg_len` in LEN_W: new length, legal 1..PAT_W.
- `cnt_clr` in 1: synchronous clear of `match_cnt`.
- `progress` out PAT_W: thermometer (`k` LSBs set) of the longest pattern prefix matched.
- `match` out 1: one-cycle pulse per detected match.
- `match_cnt` out CNT_W: saturating match count.
- `cfg_err` out 1: sticky; set by an illegal load.
- `on_led` out 1: 0 in reset, 1 from the first clock edge after reset release.

## Operation
- State:
  - pattern register `pat` and length register `len`;
  - history shift register `hist[PAT_W-1:0]`, where `hist[0]` is the newest bit;
  - valid-bit count `vcnt` in 0..PAT_W, saturating.
- On `trig` (and no `cfg_load`):
  - `hist` shifts to `{hist[PAT_W-2:0], data}`.
  - `vcnt` increments, saturating at PAT_W.
  - The longest `k` in 1..len is computed such that `k` ≤ new `vcnt` and `hist_new[k-1:0] == pat[len-1:len-k]`; `k`=0 if none.
  - `progress` takes the thermometer of `k`.
- Full match (`k == len`):
  - `match` is pulsed.
  - `match_cnt` increments when `PATDET_MATCH_CNT_EN` is defined.
  - If `overlap`=0, `vcnt` is forced to 0, so the next prefix search starts fresh. `progress` still shows all `len` ones for the match.
- No `trig`: `hist`, `vcnt` and `progress` hold; `match` is 0.
- `cfg_load` with 1 ≤ `cfg_len` ≤ PAT_W:
  - `pat` and `len` are updated.
  - `vcnt` and `progress` are cleared.
  - `cfg_err` is cleared.
- `cfg_load` with an illegal `cfg_len` (0 or >PAT_W):
  - `pat` and `len` are unchanged.
  - `cfg_err` is set.
  - `vcnt` and `progress` are still cleared.
- Bits of `pat` at index ≥ `len` are ignored.
- `match_cnt` saturates at all-ones; it never wraps.

## Timing
- Reset (`reset_n`=0, asynchronous):
  - `progress`=0, `match`=0, `match_cnt`=0, `cfg_err`=0, `on_led`=0.
  - `hist`=0, `vcnt`=0, `pat`=PAT_INIT, `len`=LEN_INIT.
- All outputs are registered. `progress` and `match` update on the same rising edge that samples `trig`=1, so latency is 1 cycle from strobe to output.
- Back-to-back `trig` is supported: one bit per cycle, and `match` can be high on consecutive cycles in overlap mode.
- `cfg_load` and `trig` in the same cycle: `cfg_load` wins and the data bit is discarded.
- `cnt_clr` and `match` in the same cycle: the clear wins and `match_cnt`=0.
- `reset_n` asserted mid-pattern: partial progress is lost immediately, without waiting for a clock edge.
- Changing `overlap` between strobes affects only matches detected at later strobes.

## Configuration
- `PATDET_MATCH_CNT_EN` defined: counter logic is built and `cnt_clr` is honoured.
- `PATDET_MATCH_CNT_EN` undefined: `match_cnt` is tied to 0, `cnt_clr` is ignored, and all ports remain present.

## Test plan
- Reset defaults, `overlap`=0, stream 1,1,0,1,0 on consecutive `trig`s:
  - `progress` is 00001, 00011, 00111, 01111, 11111.
  - `match` pulses once, on the 5th strobe.
  - `match_cnt`=1.
- Fallback: stream 1,1,1,0,1,0 → `progress` is 00001, 00011, 00011, 00111, 01111, 11111, with one match.
- Overlap: load pattern 2'b11, `cfg_len`=2; stream 1,1,1,1.
  - `overlap`=1: `match` is high on strobes 2, 3 and 4, and `match_cnt`=3.
  - `overlap`=0: matches on strobes 2 and 4 only.
- Sparse `trig`: stream 1,1,0,1,0 with `trig` gaps of 0–3 idle cycles, and `data` toggling while `trig`=0 → identical result to the first scenario.
- Config:
  - `cfg_load` with `cfg_len`=0 → `cfg_err`=1 and the pattern is kept.
  - Then a legal load → `cfg_err`=0.
  - `cfg_load` together with `trig` → that bit is ignored and `progress`=0.
- Counter (`CNT_W`=2) with 5 matches → `match_cnt` saturates at 3. `cnt_clr` in the same cycle as a match → 0. Asserting `reset_n`=0 mid-stream → all outputs are 0 asynchronously.
